// File: rtl/cbfp_block_normalizer_pkg.sv
// Shared types and arithmetic for the CBFP block normalizer.
// CBFP_ROUND_EN selects round-half-up with positive saturation on the right-shift path.
package cbfp_pkg;

  localparam int DIN_W         = 25;
  localparam int DOUT_W        = 12;
  localparam int CNT_W         = $clog2(DIN_W);
  localparam int PIVOT         = DIN_W - DOUT_W;
  localparam int DEF_LANES     = 8;
  localparam int DEF_BLK_BEATS = 4;

  typedef logic signed [DIN_W-1:0]  sample_t;
  typedef logic signed [DOUT_W-1:0] dout_t;
  typedef logic [CNT_W-1:0]         cnt_t;

  typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL, BK_DRAINING} bank_st_e;

  // Redundant sign bits: leading bits equal to the sign, minus one.
  function automatic cnt_t lsc(input sample_t x);
    cnt_t n;
    logic run;
    n   = '0;
    run = 1'b1;
    for (int i = DIN_W-2; i >= 0; i--) begin
      run = run && (x[i] == x[DIN_W-1]);
      if (run) n = n + cnt_t'(1);
    end
    return n;
  endfunction

  function automatic dout_t cbfp_scale(input sample_t x, input cnt_t l);
    logic signed [DIN_W:0] t;
    cnt_t sh;
    t = {x[DIN_W-1], x};
    if (l >= cnt_t'(PIVOT)) begin
      // l redundant bits guarantee the shifted value fits in DOUT_W bits
      sh = l - cnt_t'(PIVOT);
      t  = t <<< sh;
      return t[DOUT_W-1:0];
    end
    sh = cnt_t'(PIVOT) - l;
`ifdef CBFP_ROUND_EN
    t = t + ((DIN_W+1)'(1) << (sh - cnt_t'(1)));
    t = t >>> sh;
    // rounding can only push past the positive limit
    if (!t[DIN_W] && t[DIN_W-1:DOUT_W-1] != '0)
      return {1'b0, {(DOUT_W-1){1'b1}}};
    return t[DOUT_W-1:0];
`else
    t = t >>> sh;
    return t[DOUT_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/cbfp_block_normalizer_if.sv
// Stream bus of the CBFP normalizer: input beats in, scaled beats plus exponent out.
interface cbfp_block_normalizer_if #(parameter int LANES = cbfp_pkg::DEF_LANES);
  logic                           valid_in;
  logic                           ready_in;
  cbfp_pkg::sample_t [LANES-1:0]  din_re;
  cbfp_pkg::sample_t [LANES-1:0]  din_im;
  logic                           valid_out;
  logic                           ready_out;
  cbfp_pkg::dout_t   [LANES-1:0]  dout_re;
  cbfp_pkg::dout_t   [LANES-1:0]  dout_im;
  cbfp_pkg::cnt_t                 blk_lz;
  logic                           sob_out;
  logic                           eob_out;

  modport slave (
    input  valid_in, din_re, din_im, ready_out,
    output ready_in, valid_out, dout_re, dout_im, blk_lz, sob_out, eob_out
  );
  modport master (
    output valid_in, din_re, din_im, ready_out,
    input  ready_in, valid_out, dout_re, dout_im, blk_lz, sob_out, eob_out
  );
endinterface

// File: rtl/cbfp_lsc_min.sv
// Combinational minimum redundant-sign count over N samples.
module cbfp_lsc_min
  import cbfp_pkg::*;
#(
  parameter int N = 2
) (
  input  sample_t [N-1:0] vals,
  output cnt_t            min_lsc
);

  always_comb begin
    min_lsc = cnt_t'(DIN_W-1);
    for (int i = 0; i < N; i++)
      if (lsc(vals[i]) < min_lsc) min_lsc = lsc(vals[i]);
  end

endmodule

// File: rtl/cbfp_block_normalizer.sv
// Ping-pong buffered convergent block-floating-point normalizer.
// Build option: CBFP_ROUND_EN (rounding/saturation on the right-shift path, see cbfp_pkg).
module cbfp_block_normalizer
  import cbfp_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int BLK_BEATS = DEF_BLK_BEATS
) (
  input logic clk,
  input logic rstn,
  cbfp_block_normalizer_if.slave bus
);

  localparam int            BW   = $clog2(BLK_BEATS);
  localparam logic [BW-1:0] LAST = BW'(BLK_BEATS-1);

  typedef sample_t [LANES-1:0] svec_t;
  typedef dout_t   [LANES-1:0] dvec_t;

  bank_st_e      bank_st [2];
  cnt_t          lz      [2];
  cnt_t          run_min;
  logic          wr_bank, rd_bank;
  logic [BW-1:0] wr_cnt, rd_cnt;
  svec_t         mem_re  [2][BLK_BEATS];
  svec_t         mem_im  [2][BLK_BEATS];

  cnt_t  beat_min, new_min;
  logic  accept, rd_avail, load;
  dvec_t sc_re, sc_im;

  cbfp_lsc_min #(.N(2*LANES)) u_lsc_min (
    .vals    ({bus.din_re, bus.din_im}),
    .min_lsc (beat_min)
  );

  assign bus.ready_in = rstn &&
                        (bank_st[wr_bank] == BK_EMPTY || bank_st[wr_bank] == BK_FILLING);
  assign accept   = bus.valid_in && bus.ready_in;
  assign new_min  = (wr_cnt == '0 || beat_min < run_min) ? beat_min : run_min;
  assign rd_avail = bank_st[rd_bank] == BK_FULL || bank_st[rd_bank] == BK_DRAINING;
  assign load     = (!bus.valid_out || bus.ready_out) && rd_avail;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sc_re[i] = cbfp_scale(mem_re[rd_bank][rd_cnt][i], lz[rd_bank]);
    assign sc_im[i] = cbfp_scale(mem_im[rd_bank][rd_cnt][i], lz[rd_bank]);
  end

  // Sample store carries no reset: bank state alone says what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[wr_bank][wr_cnt] <= bus.din_re;
      mem_im[wr_bank][wr_cnt] <= bus.din_im;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        bank_st[b] <= BK_EMPTY;
        lz[b]      <= '0;
      end
      run_min       <= '0;
      wr_bank       <= 1'b0;
      wr_cnt        <= '0;
      rd_bank       <= 1'b0;
      rd_cnt        <= '0;
      bus.valid_out <= 1'b0;
      bus.dout_re   <= '0;
      bus.dout_im   <= '0;
      bus.blk_lz    <= '0;
      bus.sob_out   <= 1'b0;
      bus.eob_out   <= 1'b0;
    end else begin
      // write and read sides never touch the same bank in one cycle
      if (accept) begin
        run_min <= new_min;
        if (wr_cnt == LAST) begin
          bank_st[wr_bank] <= BK_FULL;
          lz[wr_bank]      <= new_min;
          wr_bank          <= ~wr_bank;
          wr_cnt           <= '0;
        end else begin
          bank_st[wr_bank] <= BK_FILLING;
          wr_cnt           <= wr_cnt + BW'(1);
        end
      end
      if (load) begin
        bus.valid_out <= 1'b1;
        bus.dout_re   <= sc_re;
        bus.dout_im   <= sc_im;
        bus.blk_lz    <= lz[rd_bank];
        bus.sob_out   <= rd_cnt == '0;
        bus.eob_out   <= rd_cnt == LAST;
        if (rd_cnt == LAST) begin
          bank_st[rd_bank] <= BK_EMPTY;
          rd_bank          <= ~rd_bank;
          rd_cnt           <= '0;
        end else begin
          bank_st[rd_bank] <= BK_DRAINING;
          rd_cnt           <= rd_cnt + BW'(1);
        end
      end else if (bus.ready_out) begin
        bus.valid_out <= 1'b0;
        bus.sob_out   <= 1'b0;
        bus.eob_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_block_normalizer.sv
// Directed self-checking bench for cbfp_block_normalizer at default parameters.
module tb_cbfp_block_normalizer;

  localparam int L = 8;
  typedef logic [L-1:0][24:0] lanes_t;
  typedef logic [L-1:0][11:0] dvec_t;
  typedef struct {
    dvec_t      re;
    dvec_t      im;
    logic [4:0] lz;
    logic       sob;
    logic       eob;
  } cap_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cbfp_block_normalizer_if #(.LANES(L)) bus();
  cbfp_block_normalizer #(.LANES(L), .BLK_BEATS(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int   checks = 0;
  int   passes = 0;
  int   stalls = 0;
  cap_t cap[$];

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1);
  end

  function automatic lanes_t splat(input int v);
    lanes_t r;
    for (int i = 0; i < L; i++) r[i] = 25'(v);
    return r;
  endfunction

  function automatic dvec_t dsplat(input int v);
    dvec_t r;
    for (int i = 0; i < L; i++) r[i] = 12'(v);
    return r;
  endfunction

  // reference: LSC by range test, scaling by multiply / floor division
  function automatic int m_lsc(input int v);
    int n = 0;
    for (int k = 0; k <= 24; k++)
      if (v >= -(1 << (24-k)) && v < (1 << (24-k))) n = k;
    return n;
  endfunction

  function automatic int m_scale(input int v, input int l);
    int d, q;
    if (l >= 13) return v * (1 << (l-13));
    d = 1 << (13-l);
`ifdef CBFP_ROUND_EN
    v = v + d/2;
`endif
    q = v / d;
    if (v % d != 0 && v < 0) q = q - 1;
`ifdef CBFP_ROUND_EN
    if (q > 2047) q = 2047;
`endif
    return q;
  endfunction

  function automatic int bp_val(input int k, input int j, input int i);
    return (k*37 + j*5 + i) * (1 << (3*k));
  endfunction

  function automatic lanes_t bp_beat(input int k, input int j, input bit neg);
    lanes_t r;
    for (int i = 0; i < L; i++) r[i] = 25'(neg ? -bp_val(k, j, i) : bp_val(k, j, i));
    return r;
  endfunction

  function automatic int bp_lz(input int k);
    int m = 24;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < L; i++) begin
        if (m_lsc(bp_val(k, j, i)) < m) m = m_lsc(bp_val(k, j, i));
        if (m_lsc(-bp_val(k, j, i)) < m) m = m_lsc(-bp_val(k, j, i));
      end
    return m;
  endfunction

  function automatic dvec_t bp_exp(input int k, input int j, input bit neg);
    dvec_t r;
    for (int i = 0; i < L; i++)
      r[i] = 12'(m_scale(neg ? -bp_val(k, j, i) : bp_val(k, j, i), bp_lz(k)));
    return r;
  endfunction

  // logs the transfer due at the coming posedge, then moves to the next negedge
  task automatic tick();
    cap_t c;
    if (rstn && bus.valid_out && bus.ready_out) begin
      c.re  = bus.dout_re;
      c.im  = bus.dout_im;
      c.lz  = bus.blk_lz;
      c.sob = bus.sob_out;
      c.eob = bus.eob_out;
      cap.push_back(c);
    end
    @(negedge clk);
  endtask

  task automatic push_beat(input lanes_t re, input lanes_t im);
    int g;
    g = 0;
    bus.valid_in = 1'b1;
    bus.din_re   = re;
    bus.din_im   = im;
    while (!bus.ready_in && g < 100) begin tick(); g++; stalls++; end
    if (!bus.ready_in) begin
      checks++;
      $display("FAIL push_timeout ready_in=%b after %0d cycles, required 1", bus.ready_in, g);
    end else tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int g = 0; g < 100 && cap.size() < n; g++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.valid_in = 1'b0; bus.ready_out = 1'b0;
    bus.din_re = '0; bus.din_im = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.sob_out !== 1'b0 || bus.eob_out !== 1'b0)
      $display("FAIL reset_ctrl valid/sob/eob=%b%b%b, required 000", bus.valid_out, bus.sob_out, bus.eob_out);
    else passes++;
    checks++;
    if (bus.dout_re !== '0 || bus.dout_im !== '0 || bus.blk_lz !== '0)
      $display("FAIL reset_data re=%h im=%h lz=%0d, required 0", bus.dout_re, bus.dout_im, bus.blk_lz);
    else passes++;
    checks++;
    if (bus.ready_in !== 1'b0) $display("FAIL reset_ready ready_in=%b, required 0", bus.ready_in);
    else passes++;
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.ready_in !== 1'b1) $display("FAIL release_ready ready_in=%b, required 1", bus.ready_in);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_ones();
    bus.ready_out = 1'b1; cap.delete();
    for (int j = 0; j < 4; j++) push_beat(splat(1), splat(1));
    checks++;
    if (bus.valid_out !== 1'b0) $display("FAIL latency_early valid_out=%b, required 0", bus.valid_out);
    else passes++;
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.sob_out !== 1'b1)
      $display("FAIL latency_first valid/sob=%b%b, required 11", bus.valid_out, bus.sob_out);
    else passes++;
    wait_beats(4);
    checks++;
    if (cap.size() != 4) $display("FAIL ones_count got=%0d, required 4", cap.size());
    else passes++;
    for (int j = 0; j < cap.size(); j++) begin
      checks++;
      if (cap[j].lz !== 5'd23 || cap[j].re !== dsplat(1024) || cap[j].im !== dsplat(1024))
        $display("FAIL ones_beat%0d lz=%0d re=%h, required lz=23 re=%h", j, cap[j].lz, cap[j].re, dsplat(1024));
      else passes++;
      checks++;
      if (cap[j].sob !== (j == 0) || cap[j].eob !== (j == 3))
        $display("FAIL ones_flags%0d sob/eob=%b%b, required %b%b", j, cap[j].sob, cap[j].eob, j == 0, j == 3);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    bus.ready_out = 1'b1; cap.delete(); stalls = 0;
    for (int j = 0; j < 4; j++) push_beat(splat(-1), splat(-1));
    for (int j = 0; j < 4; j++) push_beat(splat(0), splat(0));
    wait_beats(8);
    checks++;
    if (stalls != 0 || cap.size() != 8)
      $display("FAIL b2b_flow stalls=%0d beats=%0d, required 0 and 8", stalls, cap.size());
    else passes++;
    for (int j = 0; j < cap.size(); j++) begin
      checks++;
      if (cap[j].lz !== 5'd24 || cap[j].re !== dsplat(j < 4 ? -2048 : 0) ||
          cap[j].im !== dsplat(j < 4 ? -2048 : 0) ||
          cap[j].sob !== (j % 4 == 0) || cap[j].eob !== (j % 4 == 3))
        $display("FAIL b2b_beat%0d lz=%0d re=%h sob/eob=%b%b, required lz=24 re=%h", j,
                 cap[j].lz, cap[j].re, cap[j].sob, cap[j].eob, dsplat(j < 4 ? -2048 : 0));
      else passes++;
    end
  endtask

  task automatic test_right_shift();
    lanes_t re, im;
    dvec_t  er, ei;
    bus.ready_out = 1'b1; cap.delete();
    re = '0; im = '0; re[0] = 25'd4096; im[1] = 25'd3;
    push_beat(re, im);
    for (int j = 1; j < 4; j++) push_beat('0, '0);
    re = '0; re[0] = 25'h0FFFFFF;
    push_beat(re, '0);
    for (int j = 1; j < 4; j++) push_beat('0, '0);
    wait_beats(8);
    checks++;
    if (cap.size() != 8) $display("FAIL rshift_count got=%0d, required 8", cap.size());
    else passes++;
    if (cap.size() == 8) begin
      er = '0; ei = '0; er[0] = 12'd1024;
`ifdef CBFP_ROUND_EN
      ei[1] = 12'd1;
`endif
      checks++;
      if (cap[0].lz !== 5'd11 || cap[0].re !== er || cap[0].im !== ei)
        $display("FAIL mixed lz=%0d re=%h im=%h, required lz=11 re=%h im=%h", cap[0].lz, cap[0].re, cap[0].im, er, ei);
      else passes++;
      er = '0; er[0] = 12'd2047;
      checks++;
      if (cap[4].lz !== 5'd0 || cap[4].re !== er || cap[4].im !== '0)
        $display("FAIL max lz=%0d re=%h, required lz=0 re=%h", cap[4].lz, cap[4].re, er);
      else passes++;
      checks++;
      if (cap[3].re !== '0 || cap[7].re !== '0 || cap[7].lz !== 5'd0)
        $display("FAIL rshift_zero re3=%h re7=%h lz7=%0d, required 0", cap[3].re, cap[7].re, cap[7].lz);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.ready_out = 1'b0; cap.delete(); n = 0;
    while (bus.ready_in && n < 20) begin
      bus.valid_in = 1'b1;
      bus.din_re = bp_beat(n / 4, n % 4, 1'b0);
      bus.din_im = bp_beat(n / 4, n % 4, 1'b1);
      tick();
      n++;
    end
    checks++;
    if (n != 8) $display("FAIL bp_accepts got=%0d, required 8", n);
    else passes++;
    bus.din_re = bp_beat(2, 0, 1'b0);
    bus.din_im = bp_beat(2, 0, 1'b1);
    repeat (3) tick();
    checks++;
    if (bus.ready_in !== 1'b0 || bus.valid_out !== 1'b1 || bus.sob_out !== 1'b1)
      $display("FAIL bp_stall ready_in/valid/sob=%b%b%b, required 011", bus.ready_in, bus.valid_out, bus.sob_out);
    else passes++;
    checks++;
    if (bus.dout_re !== bp_exp(0, 0, 1'b0) || bus.blk_lz !== 5'(bp_lz(0)))
      $display("FAIL bp_hold re=%h lz=%0d, required re=%h lz=%0d", bus.dout_re, bus.blk_lz, bp_exp(0, 0, 1'b0), bp_lz(0));
    else passes++;
    bus.ready_out = 1'b1;
    for (int j = 0; j < 4; j++) push_beat(bp_beat(2, j, 1'b0), bp_beat(2, j, 1'b1));
    wait_beats(12);
    repeat (5) tick();
    checks++;
    if (cap.size() != 12) $display("FAIL bp_count got=%0d, required 12", cap.size());
    else passes++;
    for (int b = 0; b < cap.size() && b < 12; b++) begin
      checks++;
      if (cap[b].lz !== 5'(bp_lz(b / 4)) || cap[b].re !== bp_exp(b / 4, b % 4, 1'b0) ||
          cap[b].im !== bp_exp(b / 4, b % 4, 1'b1) ||
          cap[b].sob !== (b % 4 == 0) || cap[b].eob !== (b % 4 == 3))
        $display("FAIL bp_beat%0d lz=%0d re=%h, required lz=%0d re=%h", b, cap[b].lz, cap[b].re,
                 bp_lz(b / 4), bp_exp(b / 4, b % 4, 1'b0));
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    // reset while filling beat 2
    bus.ready_out = 1'b1; cap.delete();
    push_beat(splat(7), splat(7));
    push_beat(splat(7), splat(7));
    bus.valid_in = 1'b1; bus.din_re = splat(100000); bus.din_im = splat(100000);
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b0)
      $display("FAIL rst_fill valid/ready_in=%b%b, required 00", bus.valid_out, bus.ready_in);
    else passes++;
    bus.valid_in = 1'b0;
    @(negedge clk); rstn = 1'b1; @(negedge clk);
    cap.delete();
    for (int j = 0; j < 4; j++) push_beat(splat(5), splat(-5));
    wait_beats(4);
    repeat (10) tick();
    checks++;
    if (cap.size() != 4) $display("FAIL rst_fill_count got=%0d, required 4", cap.size());
    else passes++;
    for (int j = 0; j < cap.size(); j++) begin
      checks++;
      if (cap[j].lz !== 5'd21 || cap[j].re !== dsplat(1280) || cap[j].im !== dsplat(-1280))
        $display("FAIL rst_fill_beat%0d lz=%0d re=%h im=%h, required lz=21 re=%h", j, cap[j].lz, cap[j].re, cap[j].im, dsplat(1280));
      else passes++;
    end
    // reset while the output register holds a stalled beat
    bus.ready_out = 1'b0; cap.delete();
    for (int j = 0; j < 4; j++) push_beat(splat(1), splat(1));
    tick(); tick();
    checks++;
    if (bus.valid_out !== 1'b1) $display("FAIL rst_drain_pre valid_out=%b, required 1", bus.valid_out);
    else passes++;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.dout_re !== '0 || bus.blk_lz !== '0 || bus.sob_out !== 1'b0)
      $display("FAIL rst_drain valid=%b re=%h lz=%0d sob=%b, required all 0", bus.valid_out, bus.dout_re, bus.blk_lz, bus.sob_out);
    else passes++;
    bus.ready_out = 1'b1;
    @(negedge clk); rstn = 1'b1; @(negedge clk);
    cap.delete();
    for (int j = 0; j < 4; j++) push_beat(splat(4096), splat(-4096));
    wait_beats(4);
    repeat (10) tick();
    checks++;
    if (cap.size() != 4) $display("FAIL rst_drain_count got=%0d, required 4", cap.size());
    else passes++;
    for (int j = 0; j < cap.size(); j++) begin
      checks++;
      if (cap[j].lz !== 5'd11 || cap[j].re !== dsplat(1024) || cap[j].im !== dsplat(-1024))
        $display("FAIL rst_drain_beat%0d lz=%0d re=%h im=%h, required lz=11 re=%h", j, cap[j].lz, cap[j].re, cap[j].im, dsplat(1024));
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_back_to_back();
    test_right_shift();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
